fir_sequencer: RTL and testbench

//  Schedules one stereo FIR band engine once per audio sample. Each new sample written to the

---
 rtl/eq_pkg.sv | 14 +
 rtl/fir_sequencer.sv | 120 ++++++++++++
 tb/tb_fir_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared types and default sizing for the band FIR sequencer.
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEQ   = 2'd1,
        DRAIN = 2'd2,
        CAPT  = 2'd3
    } fir_seq_state_t;

    localparam int FIR_TAPS  = 1021;
    localparam int FIR_DRAIN = 2;

endpackage

// File: rtl/fir_sequencer.sv
// Runs one band FIR engine pass per queued stereo sample and registers the result.
// Optional FIR_SEQ_PEND_EN: 1-deep pending request replayed straight out of CAPT.
module fir_sequencer
    import eq_pkg::*;
#(
    parameter int N_TAPS    = FIR_TAPS,
    parameter int DRAIN_CYC = FIR_DRAIN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               smpl_vld,
    input  logic               q_full,
    input  logic signed [15:0] lft_fir_in,
    input  logic signed [15:0] rht_fir_in,
    output logic               sequencing,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rht_out,
    output logic               out_vld,
    output logic               busy,
    output logic               overrun
);

    // Shared counter must also reach DRAIN_CYC-1 should it ever exceed the tap count.
    localparam int CNT_MAX = (N_TAPS > DRAIN_CYC) ? N_TAPS : DRAIN_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SEQ_LAST   = CNT_W'(N_TAPS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    fir_seq_state_t   state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

`ifdef FIR_SEQ_PEND_EN
    logic pend, pend_nxt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef FIR_SEQ_PEND_EN
        pend_nxt  = pend;
        if (smpl_vld && state != IDLE)
            pend_nxt = 1'b1;
`endif
        case (state)
            IDLE: begin
                if (smpl_vld && q_full) begin
                    state_nxt = SEQ;
                    cnt_nxt   = '0;
                end
            end
            SEQ: begin
                if (cnt == SEQ_LAST) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = CAPT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            CAPT: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
`ifdef FIR_SEQ_PEND_EN
                // A request landing in this very cycle counts as pending too.
                if ((pend || smpl_vld) && q_full)
                    state_nxt = SEQ;
                pend_nxt = 1'b0;
`endif
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sequencing <= 1'b0;
            out_vld    <= 1'b0;
            lft_out    <= '0;
            rht_out    <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            // Decoded from the next state so the engine input comes straight off a flop.
            sequencing <= (state_nxt == SEQ);
            out_vld    <= (state_nxt == CAPT);
            if (state_nxt == CAPT) begin
                lft_out <= lft_fir_in;
                rht_out <= rht_fir_in;
            end
            if (smpl_vld && state != IDLE)
                overrun <= 1'b1;
        end
    end

`ifdef FIR_SEQ_PEND_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend <= 1'b0;
        else
            pend <= pend_nxt;
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer against a pass-timing reference model.
module tb_fir_sequencer;

    localparam int N   = 4;
    localparam int D   = 2;
    localparam int LAT = N + D;
`ifdef FIR_SEQ_PEND_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               smpl_vld = 1'b0;
    logic               q_full = 1'b0;
    logic signed [15:0] lft_fir_in = '0;
    logic signed [15:0] rht_fir_in = '0;
    logic               sequencing, out_vld, busy, overrun;
    logic signed [15:0] lft_out, rht_out;

    int vectors = 0;
    int miscompares = 0;

    fir_sequencer #(.N_TAPS(N), .DRAIN_CYC(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .smpl_vld   (smpl_vld),
        .q_full     (q_full),
        .lft_fir_in (lft_fir_in),
        .rht_fir_in (rht_fir_in),
        .sequencing (sequencing),
        .lft_out    (lft_out),
        .rht_out    (rht_out),
        .out_vld    (out_vld),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a pass started at edge s owns edges s+1..s+LAT+1.
    longint     t, s;
    bit         active, pend;
    logic       e_seq, e_vld, e_busy, e_ovr;
    logic [15:0] e_l, e_r;

    always @(posedge clk or negedge rst_n) begin : model
        longint nt, ns, d;
        bit     na, np, in_pass;
        if (!rst_n) begin
            t <= 0; s <= 0; active <= 0; pend <= 0;
            e_seq <= 0; e_vld <= 0; e_busy <= 0; e_ovr <= 0; e_l <= '0; e_r <= '0;
        end else begin
            nt = t + 1; ns = s; na = active; np = pend;
            in_pass = active && (nt <= s + LAT + 1);
            if (in_pass && smpl_vld) begin
                e_ovr <= 1'b1;
                if (PEND) np = 1'b1;
            end
            if (active && nt == s + LAT + 1) begin
                if (PEND && np && q_full) ns = nt;
                else na = 1'b0;
                np = 1'b0;
            end else if (!in_pass && smpl_vld && q_full) begin
                na = 1'b1;
                ns = nt;
            end
            d = nt - ns;
            e_seq  <= na && (d < N);
            e_vld  <= na && (d == LAT);
            e_busy <= na && (d <= LAT);
            if (na && d == LAT) begin
                e_l <= lft_fir_in;
                e_r <= rht_fir_in;
            end
            t <= nt; s <= ns; active <= na; pend <= np;
        end
    end

    logic [35:0] obs, expv;
    assign obs  = {sequencing, out_vld, busy, overrun, lft_out, rht_out};
    assign expv = {e_seq, e_vld, e_busy, e_ovr, e_l, e_r};

    task automatic drive(input logic sv, input logic qf, input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        smpl_vld   = sv;
        q_full     = qf;
        lft_fir_in = l;
        rht_fir_in = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (obs !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=%h", obs, 36'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 16'h1111, 16'h2222);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_single_pass();
        drive(1, 1, 16'h1234, 16'hFEDC);
        for (int c = 1; c <= 9; c++) begin
            drive(0, 1, 16'h1234, 16'hFEDC);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL single_pass cyc=%0d got=%h want=%h", c, obs, expv);
            end
        end
        vectors++;
        if ({lft_out, rht_out, overrun} !== {16'h1234, 16'hFEDC, 1'b0}) begin
            miscompares++;
            $display("FAIL single_pass_data got=%h/%h ovr=%b want=1234/fedc ovr=0", lft_out, rht_out, overrun);
        end
    endtask

    task automatic test_no_qfull();
        drive(1, 0, 16'h5555, 16'hAAAA);
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if (obs !== expv || sequencing !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL no_qfull cyc=%0d got=%h want=%h", c, obs, expv);
            end
            drive(0, 0, 16'h5555, 16'hAAAA);
        end
    endtask

    task automatic test_overrun();
        drive(1, 1, 16'h0BAD, 16'hF00D);
        for (int c = 1; c <= 20; c++) begin
            drive(c == 3, 1, $urandom, $urandom);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL overrun cyc=%0d got=%h want=%h", c, obs, expv);
            end
        end
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky got=%b want=1", overrun);
        end
    endtask

    task automatic test_reset_mid_pass();
        drive(1, 1, 16'h7777, 16'h8888);
        drive(0, 1, 16'h7777, 16'h8888);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_mid_pass got=%h want=%h", obs, 36'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 16'h4321, 16'hCDEF);
        for (int c = 1; c <= 8; c++) begin
            drive(0, 1, 16'h4321, 16'hCDEF);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL reset_then_pass cyc=%0d got=%h want=%h", c, obs, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int p = 0; p < 20; p++) begin
            for (int c = 0; c < 8; c++) begin
                drive(c == 0, 1, $urandom, $urandom);
                if (out_vld === 1'b1) pulses++;
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL back_to_back pass=%0d cyc=%0d got=%h want=%h", p, c, obs, expv);
                end
            end
        end
        vectors++;
        if (pulses != 20 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back_count got=%0d ovr=%b want=20 ovr=0", pulses, overrun);
        end
    endtask

    task automatic test_random();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(5) == 0, $urandom_range(4) != 0, $urandom, $urandom);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h want=%h", c, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_no_qfull();
        test_overrun();
        test_reset_mid_pass();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
